// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : md_sequencer
// Purpose  : Multi-cycle multiply/divide sequencer for the EX stage. Accepts
//            one MD op, stays busy for a fixed latency, then commits the
//            64-bit result to HI/LO. Also handles mthi/mtlo, drives the HI/LO
//            read mux and raises a stall request for the hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
module md_sequencer #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_sel,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] out
);

    localparam int c_max_lat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int c_cnt_w   = (c_max_lat > 1) ? $clog2(c_max_lat) : 1;

    localparam logic [c_cnt_w-1:0] c_mult_ld = c_cnt_w'(MULT_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_div_ld  = c_cnt_w'(DIV_LAT - 1);

    localparam logic [2:0] c_op_mult  = 3'd0;
    localparam logic [2:0] c_op_multu = 3'd1;
    localparam logic [2:0] c_op_div   = 3'd2;
    localparam logic [2:0] c_op_divu  = 3'd3;
    localparam logic [2:0] c_op_mthi  = 3'd4;
    localparam logic [2:0] c_op_mtlo  = 3'd5;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt,   w_cnt_nxt;
    logic [63:0]          r_pend,  w_pend_nxt;
    logic                 r_pend_wr, w_pend_wr_nxt;
    logic [31:0]          r_hi,    w_hi_nxt;
    logic [31:0]          r_lo,    w_lo_nxt;

    // Arithmetic datapath, evaluated on the live operands; only the accepting
    // edge captures it, so later operand changes are harmless.
    logic               w_b_zero;
    logic               w_div_ovf;
    logic signed [31:0] w_sdiv_b;
    logic [31:0]        w_udiv_b;
    logic signed [63:0] w_smul;
    logic [63:0]        w_umul;
    logic signed [31:0] w_squo, w_srem;
    logic [31:0]        w_uquo, w_urem;
    logic [63:0]        w_result;

    assign w_b_zero  = (B == 32'd0);
    // INT_MIN / -1 overflows; dividing by 1 instead yields the same wrapped
    // quotient and a zero remainder without relying on undefined behaviour.
    assign w_div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    // Divisor is forced to 1 when it is zero so the datapath never sees /0;
    // the divide-by-zero result is discarded anyway.
    assign w_sdiv_b  = (w_b_zero || w_div_ovf) ? 32'sd1 : $signed(B);
    assign w_udiv_b  = w_b_zero ? 32'd1 : B;

    assign w_smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_umul = {32'd0, A} * {32'd0, B};
    assign w_squo = $signed(A) / w_sdiv_b;
    assign w_srem = $signed(A) % w_sdiv_b;
    assign w_uquo = A / w_udiv_b;
    assign w_urem = A % w_udiv_b;

    // Select the {hi,lo} image for the issued op (div: hi=remainder, lo=quotient).
    always_comb begin
        w_result = 64'd0;
        case (op)
            c_op_mult:  w_result = w_smul;
            c_op_multu: w_result = w_umul;
            c_op_div:   w_result = {w_srem, w_squo};
            c_op_divu:  w_result = {w_urem, w_uquo};
            default:    w_result = 64'd0;
        endcase
    end

    // Next-state logic: issue/mthi/mtlo in IDLE, count down and commit in BUSY.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pend_nxt    = r_pend;
        w_pend_wr_nxt = r_pend_wr;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        c_op_mult, c_op_multu, c_op_div, c_op_divu: begin
                            w_state_nxt   = S_BUSY;
                            w_cnt_nxt     = op[1] ? c_div_ld : c_mult_ld;
                            w_pend_nxt    = w_result;
                            // Divide by zero runs full latency but never commits.
                            w_pend_wr_nxt = !(op[1] && w_b_zero);
                        end
                        c_op_mthi: w_hi_nxt = A;
                        c_op_mtlo: w_lo_nxt = A;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                // Any start seen here is dropped; stall_req holds it upstream.
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    if (r_pend_wr) begin
                        w_hi_nxt = r_pend[63:32];
                        w_lo_nxt = r_pend[31:0];
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and architectural registers; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pend    <= 64'd0;
            r_pend_wr <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_wr <= w_pend_wr_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
        end
    end

    assign busy      = (r_state == S_BUSY);
    assign stall_req = busy | (start & ~op[2]);
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign out       = rd_sel ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_sequencer
// Purpose  : Self-checking bench for md_sequencer: table of directed ops with
//            hand-computed HI/LO, plus hand-written multi-cycle corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd7;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        rd_sel = 1'b0;
    logic        busy, stall_req;
    logic [31:0] hi, lo, out;

    int errors = 0;
    int checks = 0;

    md_sequencer #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .rd_sel(rd_sel), .busy(busy), .stall_req(stall_req),
        .hi(hi), .lo(lo), .out(out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op at the next edge, then follow it through to its result.
    task automatic run_op(input vec_t v, input logic [31:0] old_hi, input logic [31:0] old_lo);
        start = 1'b1;
        op    = v.op;
        A     = v.a;
        B     = v.b;
        #1;
        chk({v.name, " stall_req@issue"}, {63'd0, stall_req}, {63'd0, (v.op <= 3'd3)});
        tick();
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        for (int k = 0; k < v.lat; k++) begin
            chk($sformatf("%s busy c%0d", v.name, k), {63'd0, busy}, 64'd1);
            chk($sformatf("%s hold c%0d", v.name, k), {hi, lo}, {old_hi, old_lo});
            tick();
        end
        chk({v.name, " busy_end"}, {63'd0, busy}, 64'd0);
        chk({v.name, " hilo"}, {hi, lo}, {v.hi, v.lo});
        rd_sel = 1'b1;
        #1;
        chk({v.name, " out_hi"}, {32'd0, out}, {32'd0, v.hi});
        rd_sel = 1'b0;
        #1;
        chk({v.name, " out_lo"}, {32'd0, out}, {32'd0, v.lo});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cur_hi, cur_lo;
        vec_t        v;

        //            name        op    a             b             hi            lo            lat
        vecs[0]  = '{"mthi",     3'd4, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
        vecs[1]  = '{"mtlo",     3'd5, 32'h0000CAFE, 32'h0,        32'h12345678, 32'h0000CAFE, 0};
        vecs[2]  = '{"mult",     3'd0, 32'd3,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[3]  = '{"multu",    3'd1, 32'd3,        32'hFFFFFFFE, 32'h00000002, 32'hFFFFFFFA, 5};
        vecs[4]  = '{"div",      3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[5]  = '{"divu",     3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
        vecs[6]  = '{"mthi_aa",  3'd4, 32'h000000AA, 32'h0,        32'h000000AA, 32'h00000003, 0};
        vecs[7]  = '{"mtlo_bb",  3'd5, 32'h000000BB, 32'h0,        32'h000000AA, 32'h000000BB, 0};
        vecs[8]  = '{"divu_z",   3'd3, 32'd5,        32'd0,        32'h000000AA, 32'h000000BB, 10};
        vecs[9]  = '{"div_z",    3'd2, 32'hFFFFFFF9, 32'd0,        32'h000000AA, 32'h000000BB, 10};
        vecs[10] = '{"div_pn",   3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[11] = '{"div_nn",   3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 10};
        vecs[12] = '{"mult_min", 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[13] = '{"multu_max",3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[14] = '{"noop6",    3'd6, 32'h77777777, 32'h1,        32'hFFFFFFFE, 32'h00000001, 0};

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset hilo", {hi, lo}, 64'd0);
        chk("reset out",  {32'd0, out}, 64'd0);

        cur_hi = 32'd0;
        cur_lo = 32'd0;
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i], cur_hi, cur_lo);
            cur_hi = vecs[i].hi;
            cur_lo = vecs[i].lo;
        end

        // Clear HI/LO, then mult 3*5 with an mtlo arriving mid-flight.
        v = '{"clr_hi", 3'd4, 32'd0, 32'd0, 32'd0, cur_lo, 0};
        run_op(v, cur_hi, cur_lo);
        v = '{"clr_lo", 3'd5, 32'd0, 32'd0, 32'd0, 32'd0, 0};
        run_op(v, 32'd0, cur_lo);
        start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd5;
        tick();                                  // edge N: accepted
        start = 1'b0;
        tick();                                  // after N+1
        start = 1'b1; op = 3'd5; A = 32'h55;
        #1;
        chk("mtlo_in_busy stall_req", {63'd0, stall_req}, 64'd1);
        tick();                                  // after N+2, mtlo dropped
        start = 1'b0;
        chk("mtlo_in_busy ignored", {hi, lo}, 64'd0);
        tick();
        tick();                                  // after N+4
        chk("mtlo_in_busy still busy", {63'd0, busy}, 64'd1);
        tick();                                  // after N+5: commit
        chk("mtlo_in_busy busy_end", {63'd0, busy}, 64'd0);
        chk("mtlo_in_busy hilo", {hi, lo}, {32'd0, 32'd15});
        tick();
        chk("mtlo_in_busy no_late", {hi, lo}, {32'd0, 32'd15});

        // Reset in the third busy cycle of a div: no commit afterwards.
        start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_mid busy", {63'd0, busy}, 64'd0);
        chk("reset_mid hilo", {hi, lo}, 64'd0);
        repeat (12) tick();
        chk("reset_mid no_late", {hi, lo}, 64'd0);
        chk("reset_mid idle", {63'd0, busy}, 64'd0);

        // Read mux follows rd_sel within the same cycle.
        v = '{"mthi_1111", 3'd4, 32'h1111, 32'd0, 32'h1111, 32'd0, 0};
        run_op(v, 32'd0, 32'd0);
        v = '{"mtlo_2222", 3'd5, 32'h2222, 32'd0, 32'h1111, 32'h2222, 0};
        run_op(v, 32'h1111, 32'd0);
        rd_sel = 1'b1;
        #1;
        chk("rdsel hi", {32'd0, out}, 64'h1111);
        rd_sel = 1'b0;
        #1;
        chk("rdsel lo", {32'd0, out}, 64'h2222);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
